// File: rtl/usrt_pkg.sv
// Shared constants for the USRT bus controller: register addresses, FSM encoding,
// IRQ mask bit positions and the captured-request record.
package usrt_pkg;

  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_TXDATA  = 2'd1;
  localparam logic [1:0] ADDR_RXDATA  = 2'd2;
  localparam logic [1:0] ADDR_IRQMASK = 2'd3;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETUP  = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_WAIT   = 2'd3;

  localparam int IRQ_RX_FULL = 0;
  localparam int IRQ_TX_IDLE = 1;

  typedef struct packed {
    logic [1:0] addr;
    logic       write;
    logic [7:0] wdata;
  } req_t;

endpackage

// File: rtl/usrt_wait_timer.sv
// Wait-state counter: clears when idle, counts while enabled and saturates at WAIT_MAX.
module usrt_wait_timer #(
  parameter int WAIT_MAX = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int CW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(WAIT_MAX);

  logic [CW-1:0] cnt_q;

  assign expired_o = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i && !expired_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/usrt_bus_ctrl.sv
// APB-style slave front end for the USRT: register decode, TX wait states with timeout.
// Optional interrupt mask register and o_Irq output are built when USRT_IRQ_EN is defined.
module usrt_bus_ctrl
  import usrt_pkg::*;
#(
  parameter int WAIT_MAX = 16
) (
  input  logic       i_Pclk,
  input  logic       i_Reset,
  input  logic       i_Psel,
  input  logic       i_Enable,
  input  logic       i_Pwrite,
  input  logic [1:0] i_Paddr,
  input  logic [7:0] i_Pwdata,
  output logic [7:0] o_Prdata,
  output logic       o_Ready,
  output logic       o_Slverr,
  output logic       o_Cfg_We,
  output logic [7:0] o_Cfg_Data,
  input  logic [7:0] i_Status,
  input  logic       i_Tx_Busy,
  output logic       o_Tx_Load,
  output logic [7:0] o_Tx_Data,
  input  logic       i_Rx_Full,
  input  logic [7:0] i_Rx_Data,
  output logic       o_Rx_Ack,
`ifdef USRT_IRQ_EN
  output logic       o_Irq,
`endif
  output logic [1:0] o_Dbg_State
);

  // Handshake: a transfer is a setup cycle (Psel=1, Enable=0) followed by access
  // cycles (Psel=1, Enable=1); it completes on the edge where o_Ready=1 is seen.
  logic [1:0] state_q, state_d;
  req_t       req_q, req_d;
  logic       cfg_we_q, cfg_we_d;
  logic       tx_load_q, tx_load_d;
  logic       rx_ack_q, rx_ack_d;
  logic [7:0] cfg_data_q, tx_data_q;

  logic in_access, in_wait, is_tx_wr, stall, expired, timeout;
  logic start, ready, dec_err, slverr, ok;
  logic [7:0] rdata;

`ifdef USRT_IRQ_EN
  logic [1:0] mask_q;
  logic       irq_q;
`endif

  assign start     = i_Psel && !i_Enable;
  assign in_access = (state_q == ST_ACCESS) && i_Psel;
  assign in_wait   = (state_q == ST_WAIT) && i_Psel;
  assign is_tx_wr  = req_q.write && (req_q.addr == ADDR_TXDATA);
  assign stall     = in_access && is_tx_wr && i_Tx_Busy;
  // Timeout only counts against a still-busy transmitter, so success wins a tie.
  assign timeout   = in_wait && i_Tx_Busy && expired;
  assign ready     = (in_access && !stall) || (in_wait && (!i_Tx_Busy || expired));

  usrt_wait_timer #(.WAIT_MAX(WAIT_MAX)) u_wait_timer (
    .clk       (i_Pclk),
    .rst       (i_Reset),
    .clr_i     (!(stall || in_wait)),
    .en_i      (stall || in_wait),
    .expired_o (expired)
  );

  always_comb begin
    dec_err = 1'b0;
    rdata   = 8'h00;
    case (req_q.addr)
      ADDR_CTRL:    rdata = i_Status;
      ADDR_RXDATA: begin
        dec_err = req_q.write || !i_Rx_Full;
        rdata   = i_Rx_Full ? i_Rx_Data : 8'h00;
      end
`ifdef USRT_IRQ_EN
      ADDR_IRQMASK: rdata = {6'b0, mask_q};
`else
      ADDR_IRQMASK: dec_err = 1'b1;
`endif
      default:      rdata = 8'h00;
    endcase
  end

  assign slverr   = ready && (timeout || dec_err);
  assign ok       = ready && !slverr;
  assign o_Ready  = ready;
  assign o_Slverr = slverr;
  assign o_Prdata = (ready && !req_q.write) ? rdata : 8'h00;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETUP;
      ST_SETUP:  state_d = (i_Psel && i_Enable) ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: begin
        if (!i_Psel)    state_d = ST_IDLE;
        else if (stall) state_d = ST_WAIT;
        else            state_d = start ? ST_SETUP : ST_IDLE;
      end
      ST_WAIT: begin
        if (!i_Psel)    state_d = ST_IDLE;
        else if (ready) state_d = start ? ST_SETUP : ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_d = req_q;
    if (state_d == ST_SETUP) begin
      req_d.addr  = i_Paddr;
      req_d.write = i_Pwrite;
      req_d.wdata = i_Pwdata;
    end
  end

  assign cfg_we_d  = ok && req_q.write && (req_q.addr == ADDR_CTRL);
  assign tx_load_d = ok && req_q.write && (req_q.addr == ADDR_TXDATA);
  assign rx_ack_d  = ok && !req_q.write && (req_q.addr == ADDR_RXDATA);

  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      req_q      <= '0;
      cfg_we_q   <= 1'b0;
      tx_load_q  <= 1'b0;
      rx_ack_q   <= 1'b0;
      cfg_data_q <= 8'h00;
      tx_data_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      req_q     <= req_d;
      cfg_we_q  <= cfg_we_d;
      tx_load_q <= tx_load_d;
      rx_ack_q  <= rx_ack_d;
      if (cfg_we_d)  cfg_data_q <= req_q.wdata;
      if (tx_load_d) tx_data_q  <= req_q.wdata;
    end
  end

`ifdef USRT_IRQ_EN
  always_ff @(posedge i_Pclk or posedge i_Reset) begin
    if (i_Reset) begin
      mask_q <= 2'b00;
      irq_q  <= 1'b0;
    end else begin
      if (ok && req_q.write && (req_q.addr == ADDR_IRQMASK)) mask_q <= req_q.wdata[1:0];
      irq_q <= (mask_q[IRQ_RX_FULL] & i_Rx_Full) | (mask_q[IRQ_TX_IDLE] & ~i_Tx_Busy);
    end
  end

  assign o_Irq = irq_q;
`endif

  assign o_Cfg_We    = cfg_we_q;
  assign o_Cfg_Data  = cfg_data_q;
  assign o_Tx_Load   = tx_load_q;
  assign o_Tx_Data   = tx_data_q;
  assign o_Rx_Ack    = rx_ack_q;
  assign o_Dbg_State = state_q;

endmodule

// File: tb/tb_usrt_bus_ctrl.sv
// Directed bench for usrt_bus_ctrl: register accesses, TX wait/timeout, RX pop, reset abort.
module tb_usrt_bus_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       psel, penable, pwrite;
  logic [1:0] paddr;
  logic [7:0] pwdata, prdata, status, rx_data, cfg_data, tx_data;
  logic       ready, slverr, cfg_we, tx_busy, tx_load, rx_full, rx_ack;
  logic [1:0] dbg_state;
`ifdef USRT_IRQ_EN
  logic       irq;
`endif

  int checks = 0;
  int errors = 0;

  logic [7:0] rd;
  logic       err, done;
  int         waits;

  always #5 clk = ~clk;

  usrt_bus_ctrl #(.WAIT_MAX(16)) dut (
    .i_Pclk      (clk),
    .i_Reset     (rst),
    .i_Psel      (psel),
    .i_Enable    (penable),
    .i_Pwrite    (pwrite),
    .i_Paddr     (paddr),
    .i_Pwdata    (pwdata),
    .o_Prdata    (prdata),
    .o_Ready     (ready),
    .o_Slverr    (slverr),
    .o_Cfg_We    (cfg_we),
    .o_Cfg_Data  (cfg_data),
    .i_Status    (status),
    .i_Tx_Busy   (tx_busy),
    .o_Tx_Load   (tx_load),
    .o_Tx_Data   (tx_data),
    .i_Rx_Full   (rx_full),
    .i_Rx_Data   (rx_data),
    .o_Rx_Ack    (rx_ack),
`ifdef USRT_IRQ_EN
    .o_Irq       (irq),
`endif
    .o_Dbg_State (dbg_state)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bus transfer; tx_busy is released when the access/wait loop reaches release_at.
  task automatic xfer(input logic [1:0] a, input logic w, input logic [7:0] d,
                      input int release_at, output logic [7:0] rdv, output logic errv,
                      output int nwait, output logic donev);
    rdv = 8'h00; errv = 1'b0; nwait = 0; donev = 1'b0;
    psel = 1'b1; penable = 1'b0; paddr = a; pwrite = w; pwdata = d;
    tick();
    penable = 1'b1;
    tick();
    for (int i = 0; i < 40; i++) begin
      if (i == release_at) begin
        tx_busy = 1'b0;
        #1;
      end
      if (ready) begin
        donev = 1'b1;
        rdv   = prdata;
        errv  = slverr;
        break;
      end
      nwait++;
      tick();
    end
    tick();
    psel = 1'b0; penable = 1'b0;
    #1;
  endtask

  initial begin
    rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 2'd0; pwdata = 8'h00;
    status = 8'h5A; tx_busy = 1'b0; rx_full = 1'b0; rx_data = 8'h00;
    tick(); tick();
    chk("rst_state", dbg_state, 2'd0);
    chk("rst_ready", ready, 1'b0);
    chk("rst_strobes", {cfg_we, tx_load, rx_ack}, 3'b000);
    chk("rst_data", {cfg_data, tx_data, prdata}, 24'h0);
    rst = 1'b0;
    tick();

    xfer(2'd0, 1'b1, 8'h15, -1, rd, err, waits, done);
    chk("ctrl_wr_done", {done, err}, 2'b10);
    chk("ctrl_wr_waits", waits, 0);
    chk("ctrl_wr_strobe", {cfg_we, cfg_data}, {1'b1, 8'h15});
    tick();
    chk("ctrl_wr_strobe_end", cfg_we, 1'b0);

    xfer(2'd0, 1'b0, 8'h00, -1, rd, err, waits, done);
    chk("ctrl_rd", {done, err, rd}, {2'b10, 8'h5A});

    psel = 1'b1; penable = 1'b0; paddr = 2'd0; pwrite = 1'b1; pwdata = 8'h77;
    tick();
    psel = 1'b0;
    tick();
    chk("viol_state", dbg_state, 2'd0);
    chk("viol_no_strobe", {cfg_we, cfg_data}, {1'b0, 8'h15});

    tx_busy = 1'b1;
    xfer(2'd1, 1'b1, 8'hA5, 4, rd, err, waits, done);
    chk("tx_wait_done", {done, err}, 2'b10);
    chk("tx_wait_cycles", waits, 4);
    chk("tx_wait_load", {tx_load, tx_data}, {1'b1, 8'hA5});
    tick();
    chk("tx_wait_load_end", tx_load, 1'b0);

    tx_busy = 1'b1;
    xfer(2'd1, 1'b1, 8'h5C, -1, rd, err, waits, done);
    chk("tx_to_done", {done, err}, 2'b11);
    chk("tx_to_cycles", waits, 16);
    chk("tx_to_no_load", {tx_load, tx_data}, {1'b0, 8'hA5});
    tx_busy = 1'b0;

    xfer(2'd1, 1'b0, 8'h00, -1, rd, err, waits, done);
    chk("tx_rd", {done, err, rd}, {2'b10, 8'h00});

    rx_full = 1'b1; rx_data = 8'h3C;
    xfer(2'd2, 1'b0, 8'h00, -1, rd, err, waits, done);
    chk("rx_rd", {done, err, rd}, {2'b10, 8'h3C});
    chk("rx_ack", rx_ack, 1'b1);
    tick();
    chk("rx_ack_end", rx_ack, 1'b0);

    rx_full = 1'b0;
    xfer(2'd2, 1'b0, 8'h00, -1, rd, err, waits, done);
    chk("rx_empty", {done, err, rd}, {2'b11, 8'h00});
    chk("rx_empty_no_ack", rx_ack, 1'b0);

    xfer(2'd2, 1'b1, 8'h11, -1, rd, err, waits, done);
    chk("rx_wr_err", {done, err}, 2'b11);

`ifdef USRT_IRQ_EN
    xfer(2'd3, 1'b1, 8'h01, -1, rd, err, waits, done);
    chk("mask_wr", {done, err}, 2'b10);
    xfer(2'd3, 1'b0, 8'h00, -1, rd, err, waits, done);
    chk("mask_rd", {done, err, rd}, {2'b10, 8'h01});
    tick();
    chk("irq_low", irq, 1'b0);
    rx_full = 1'b1;
    #1;
    chk("irq_lag", irq, 1'b0);
    tick();
    chk("irq_high", irq, 1'b1);
    rx_full = 1'b0;
`else
    xfer(2'd3, 1'b1, 8'h01, -1, rd, err, waits, done);
    chk("a3_wr_err", {done, err}, 2'b11);
    xfer(2'd3, 1'b0, 8'h00, -1, rd, err, waits, done);
    chk("a3_rd_err", {done, err, rd}, {2'b11, 8'h00});
`endif

    tx_busy = 1'b1;
    psel = 1'b1; penable = 1'b0; paddr = 2'd1; pwrite = 1'b1; pwdata = 8'h99;
    tick();
    penable = 1'b1;
    tick(); tick(); tick();
    chk("pre_rst_state", dbg_state, 2'd3);
    rst = 1'b1;
    #1;
    chk("mid_rst_state", dbg_state, 2'd0);
    chk("mid_rst_outs", {ready, slverr, tx_load, cfg_we, rx_ack, tx_data, cfg_data}, 21'h0);
    psel = 1'b0; penable = 1'b0;
    tick();
    rst = 1'b0; tx_busy = 1'b0;
    tick();
    chk("post_rst_no_load", tx_load, 1'b0);
    tick();
    chk("post_rst_no_load2", {tx_load, tx_data}, 9'h0);

    xfer(2'd0, 1'b1, 8'h42, -1, rd, err, waits, done);
    chk("post_rst_ctrl", {done, err}, 2'b10);
    chk("post_rst_cfg", {cfg_we, cfg_data}, {1'b1, 8'h42});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
